// File: rtl/gap_tv_wb_drain.sv
// Write-back collector behind gap_tv: buffers whole rows in a small FIFO and
// drains each row as a sequence of narrow valid/ready beats tagged with {row, beat}.
module gap_tv_wb_drain #(
    parameter int PORT_SIZE = 32,
    parameter int ADDR_W    = 8,
    parameter int OUT_LANES = 4,
    parameter int DEPTH     = 4,
    parameter int ROWS      = 256,
    parameter int FCNT_W    = 8,
    localparam int BEATS    = PORT_SIZE / OUT_LANES,
    localparam int BIDX_W   = $clog2(BEATS),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1,
    localparam int ROW_W    = PORT_SIZE * 16,
    localparam int BEAT_W   = OUT_LANES * 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [ROW_W-1:0]         dout,
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic [BEAT_W-1:0]        m_data,
    output logic [ADDR_W+BIDX_W-1:0] m_addr,
    output logic                     m_last,
    output logic                     m_frame_end,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Handshake: a beat transfers on any rising edge where m_valid && m_ready;
    // m_valid never drops and the beat never changes until that transfer.

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ROW_W-1:0]  data_mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BIDX_W-1:0] beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic              beat_fire;
    logic              last_beat;
    logic              pop_fire;
    logic              push_fire;
    logic [ADDR_W-1:0] head_addr;
    logic [ROW_W-1:0]  head_data;

    assign head_addr = addr_mem_q[head_q];
    assign head_data = data_mem_q[head_q];

    assign m_valid     = (state_q == DRAIN);
    assign last_beat   = (beat_q == BIDX_W'(BEATS - 1));
    assign m_last      = m_valid && last_beat;
    assign m_frame_end = m_last && (head_addr == ADDR_W'(ROWS - 1));
    assign m_data      = m_valid ? head_data[beat_q * BEAT_W +: BEAT_W] : '0;
    assign m_addr      = m_valid ? {head_addr, beat_q} : '0;

    assign beat_fire = m_valid && m_ready;
    assign pop_fire  = beat_fire && last_beat;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign push_fire = wen && ((count_q != CNT_W'(DEPTH)) || pop_fire);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        beat_d      = beat_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        if (beat_fire) begin
            if (last_beat) begin
                beat_d = '0;
                head_d = head_q + PTR_W'(1);
            end else begin
                beat_d = beat_q + BIDX_W'(1);
            end
            if (m_frame_end) begin
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
        end

        if (push_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end else if (wen) begin
            overflow_d = 1'b1;
        end

        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        state_d = (count_d != '0) ? DRAIN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Row storage needs no reset: entries are only read between head and tail.
    always_ff @(posedge clk) begin
        if (push_fire && !rst) begin
            addr_mem_q[tail_q] <= waddr;
            data_mem_q[tail_q] <= dout;
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gap_tv_wb_drain.sv
// Randomized and directed bench for gap_tv_wb_drain, checked every cycle
// against a row-queue reference model.
module tb_gap_tv_wb_drain;

    localparam int PORT_SIZE = 32;
    localparam int ADDR_W    = 8;
    localparam int OUT_LANES = 4;
    localparam int DEPTH     = 4;
    localparam int ROWS      = 4;
    localparam int FCNT_W    = 3;
    localparam int BEATS     = PORT_SIZE / OUT_LANES;
    localparam int BIDX_W    = $clog2(BEATS);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int ROW_W     = PORT_SIZE * 16;
    localparam int BEAT_W    = OUT_LANES * 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wen;
    logic [ADDR_W-1:0]        waddr;
    logic [ROW_W-1:0]         dout;
    logic                     m_ready;
    logic                     m_valid;
    logic [BEAT_W-1:0]        m_data;
    logic [ADDR_W+BIDX_W-1:0] m_addr;
    logic                     m_last;
    logic                     m_frame_end;
    logic [FCNT_W-1:0]        frame_cnt;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     overflow;

    // clock / reset
    always #5 clk = ~clk;

    gap_tv_wb_drain #(
        .PORT_SIZE(PORT_SIZE), .ADDR_W(ADDR_W), .OUT_LANES(OUT_LANES),
        .DEPTH(DEPTH), .ROWS(ROWS), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .dout(dout),
        .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_addr(m_addr),
        .m_last(m_last), .m_frame_end(m_frame_end), .frame_cnt(frame_cnt),
        .count(count), .full(full), .overflow(overflow)
    );

    // scoreboard: queue of buffered rows plus drain position
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
    } row_t;

    row_t exp_q[$];
    int   m_beat;
    bit   m_ovf;
    int   m_fcnt;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic              v;
        logic [BEAT_W-1:0] d;
        logic [63:0]       a;
        logic              l;
        logic              fe;
        v  = (exp_q.size() > 0);
        d  = '0;
        a  = '0;
        l  = 1'b0;
        fe = 1'b0;
        if (v) begin
            d  = exp_q[0].data[m_beat * BEAT_W +: BEAT_W];
            a  = 64'({exp_q[0].addr, BIDX_W'(m_beat)});
            l  = (m_beat == BEATS - 1);
            fe = l && (exp_q[0].addr == ADDR_W'(ROWS - 1));
        end
        check("m_valid", 64'(m_valid), 64'(v));
        check("m_data", 64'(m_data), 64'(d));
        check("m_addr", 64'(m_addr), a);
        check("m_last", 64'(m_last), 64'(l));
        check("m_frame_end", 64'(m_frame_end), 64'(fe));
        check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
        check("count", 64'(count), 64'(exp_q.size()));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // What one rising edge does to the buffered rows, given the inputs.
    function automatic void model_edge(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                                       input logic [ROW_W-1:0] d, input logic rdy);
        int   n;
        bit   popped;
        row_t nr;
        if (r) begin
            exp_q.delete();
            m_beat = 0;
            m_ovf  = 1'b0;
            m_fcnt = 0;
            return;
        end
        n      = exp_q.size();
        popped = 1'b0;
        if (n > 0 && rdy) begin
            if (m_beat < BEATS - 1) begin
                m_beat++;
            end else begin
                if (exp_q[0].addr == ADDR_W'(ROWS - 1))
                    m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
                m_beat = 0;
                void'(exp_q.pop_front());
                popped = 1'b1;
            end
        end
        if (w) begin
            if (n < DEPTH || popped) begin
                nr.addr = a;
                nr.data = d;
                exp_q.push_back(nr);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endfunction

    // driver: apply inputs for one edge, advance the model, check after the edge
    task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [ROW_W-1:0] d, input logic rdy);
        rst     = r;
        wen     = w;
        waddr   = a;
        dout    = d;
        m_ready = rdy;
        model_edge(r, w, a, d, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [ROW_W-1:0] make_row(input logic [15:0] base);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < PORT_SIZE; i++) r[i*16 +: 16] = base + 16'(i);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; dout = '0; m_ready = 1'b0;
        exp_q.delete();
        m_beat = 0; m_ovf = 1'b0; m_fcnt = 0;

        // single row, always ready
        do_reset();
        step(1'b0, 1'b1, 8'd5, make_row(16'h0100), 1'b1);
        check("t1_beat0_data", 64'(m_data), 64'h0103_0102_0101_0100);
        check("t1_beat0_addr", 64'(m_addr), 64'({8'd5, 3'd0}));
        for (int b = 1; b < BEATS; b++) idle(1'b1);
        check("t1_last_beat7", 64'(m_last), 64'd1);
        idle(1'b1);
        check("t1_count_empty", 64'(count), 64'd0);

        // single row under 1,0,0 backpressure
        do_reset();
        step(1'b0, 1'b1, 8'd7, make_row(16'h0200), 1'b1);
        for (int i = 1; i < 40; i++) idle(i % 3 == 0);
        check("t2_drained", 64'(m_valid), 64'd0);

        // overflow with the consumer stalled
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, ADDR_W'(i), make_row(16'(i * 256)), 1'b0);
            if (i == 3) check("t3_full", 64'(full), 64'd1);
        end
        check("t3_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH * BEATS; i++) idle(1'b1);
        check("t3_empty", 64'(count), 64'd0);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // push at full coinciding with the last-beat pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, ADDR_W'(i + 8), rand_row(), 1'b0);
        for (int i = 0; i < BEATS - 1; i++) idle(1'b1);
        check("t4_on_beat7", 64'(m_last), 64'd1);
        step(1'b0, 1'b1, 8'd9, rand_row(), 1'b1);
        check("t4_count", 64'(count), 64'd4);
        check("t4_no_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH * BEATS; i++) idle(1'b1);

        // two frames of four rows
        do_reset();
        for (int r = 0; r < 2 * ROWS; r++) begin
            step(1'b0, 1'b1, ADDR_W'(r % ROWS), rand_row(), 1'b1);
            for (int b = 1; b < BEATS; b++) idle(1'b1);
        end
        idle(1'b1);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd2);

        // reset in the middle of a drain
        do_reset();
        step(1'b0, 1'b1, 8'd1, rand_row(), 1'b1);
        step(1'b0, 1'b1, 8'd2, rand_row(), 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("t6_at_beat3", 64'(m_addr[BIDX_W-1:0]), 64'd3);
        do_reset();
        check("t6_valid", 64'(m_valid), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        idle(1'b1);
        step(1'b0, 1'b1, 8'd3, rand_row(), 1'b1);
        check("t6_fresh_beat0", 64'(m_addr), 64'({8'd3, 3'd0}));
        for (int b = 1; b < BEATS + 2; b++) idle(1'b1);

        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 5) == 0,
                 ADDR_W'($urandom_range(0, 7)),
                 rand_row(),
                 $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gap_tv_wb_drain.md
Name: gap_tv_wb_drain

Overview:
- Write-back collector directly downstream of gap_tv.
- Captures each 512-bit row that gap_tv writes through its wen/waddr/dout write port, and buffers it in a small row FIFO.
- Serialises each buffered row into narrow valid/ready beats for the output memory/DMA side.
- Tags every beat with its row/beat address and frame boundaries, so the consumer no longer needs a wide single-cycle write port.

Parameters:
PORT_SIZE, 32, 16-bit lanes per gap_tv row (row width PORT_SIZE*16)
ADDR_W, 8, width of gap_tv waddr
OUT_LANES, 4, 16-bit lanes per output beat; must divide PORT_SIZE; BEATS = PORT_SIZE/OUT_LANES
DEPTH, 4, row FIFO depth in entries; power of two, >= 2
ROWS, 256, row addresses per frame; waddr == ROWS-1 marks the last row of a frame
FCNT_W, 8, width of the completed-frame counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
wen  in  1  gap_tv row write strobe
waddr  in  ADDR_W  gap_tv row address
dout  in  PORT_SIZE*16  gap_tv row data; lane i is bits [i*16 +: 16]
m_ready  in  1  consumer ready
m_valid  out  1  beat valid
m_data  out  OUT_LANES*16  beat data; lowest-numbered lane in the LSBs
m_addr  out  ADDR_W+log2(BEATS)  {row address, beat index}
m_last  out  1  last beat of the current row
m_frame_end  out  1  last beat of row ROWS-1
frame_cnt  out  FCNT_W  completed frames, i.e. m_frame_end handshakes; wraps modulo 2^FCNT_W
count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
full  out  1  count == DEPTH
overflow  out  1  sticky; set when a wen row is dropped

Behaviour:
- Reset (rst high at a clock edge): count=0, beat=0, FIFO pointers=0, overflow=0, frame_cnt=0. Consequently m_valid, m_last, m_frame_end and full are 0. m_data and m_addr are 0 while m_valid=0.
- Reset mid-operation: all buffered rows and any partial drain are discarded. Nothing is emitted after reset until a new wen arrives.
- Push fire: wen && (count < DEPTH || pop_fire). The entry {waddr, dout} is written at the tail and the tail pointer advances, wrapping modulo DEPTH.
- Drop: wen && count == DEPTH && !pop_fire. The row is discarded, overflow is set to 1, and FIFO state is unchanged. overflow clears only on rst.
- Drain, two states:
  - IDLE: count == 0.
  - DRAIN: count > 0.
  - m_valid is 1 exactly in DRAIN.
- Beat output: m_data = head.data lanes [beat*OUT_LANES +: OUT_LANES]. m_addr = {head.addr, beat}. m_last = (beat == BEATS-1). m_frame_end = m_last && head.addr == ROWS-1.
- Beat fire: m_valid && m_ready.
  - If beat < BEATS-1: beat increments.
  - Otherwise pop_fire: beat returns to 0 and the head pointer advances.
- Simultaneous push and pop: count is unchanged. This applies at full as well; the pushed row is accepted.
- Frame counter: frame_cnt increments on a fired beat with m_frame_end=1, wrapping from 2^FCNT_W-1 to 0.
- Latency: a wen at edge k into an empty FIFO gives m_valid=1 in the cycle after edge k, showing beat 0 of that row. A row drains in BEATS cycles at best; full throughput is one row per BEATS cycles.
- Stability: while m_valid && !m_ready, m_data, m_addr, m_last and m_frame_end hold steady.
- Ordering: rows drain in arrival order. waddr is passed through unchecked; repeated or out-of-order addresses are emitted as received.
- Idle outputs: in IDLE, m_data, m_addr, m_last and m_frame_end read 0.

Test Plan:
1. Single row: waddr=5, lane i = 16'h0100+i, m_ready=1.
   - Beats 0..7 appear on consecutive cycles starting the cycle after wen.
   - Beat 0 has m_data={16'h0103,16'h0102,16'h0101,16'h0100} and m_addr={8'd5,3'd0}.
   - m_last=1 only on beat 7; count returns to 0 afterwards.
2. Backpressure: m_ready toggles 1,0,0,1,... during the single-row case.
   - m_data and m_addr hold steady during the ready-low cycles.
   - The full beat sequence is unchanged and m_valid never drops mid-row.
3. Overflow: m_ready=0 and 5 consecutive wen rows (waddr 0..4).
   - full=1 after 4 rows; row 4 is dropped and overflow=1.
   - With m_ready=1, exactly rows 0..3 drain (32 beats), and overflow stays 1.
4. Push at full with pop: FIFO is full and sitting on beat 7 with m_ready=1; a wen arrives in that same cycle.
   - The row is accepted, count stays 4, and overflow stays 0.
5. Frame end: ROWS=4, rows 0..3 written twice (8 rows), m_ready=1.
   - m_frame_end pulses on the last beat of each row 3.
   - frame_cnt goes 0→1→2.
6. Reset mid-drain: rst=1 for one cycle at beat 3 of a row, with 2 rows buffered.
   - The next cycle shows m_valid=0, count=0, frame_cnt=0, overflow=0.
   - A fresh wen drains normally starting from beat 0.
